// File: rtl/life_pkg.sv
// life_pkg: shared types and constants for the 8x8 Game of Life frame scheduler.
//   GRID_N / GRID_CELLS : grid geometry (8x8 = 64 cells, row-major, bit i*8+j)
//   frame_t             : one full grid frame
//   sched_state_t       : scheduler FSM states
package life_pkg;

    localparam int unsigned GRID_N     = 8;
    localparam int unsigned GRID_CELLS = GRID_N * GRID_N;

    typedef logic [GRID_CELLS-1:0] frame_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        CALC,
        SETTLE,
        PUBLISH
    } sched_state_t;

endpackage

// File: rtl/life_tick_divider.sv
// life_tick_divider: generation-period counter for the frame scheduler.
//   clk   in  system clock
//   rst   in  synchronous, active-high reset
//   clear in  force tick_cnt to 0 (has priority over en)
//   en    in  count enable
//   tick  out high while en=1 and tick_cnt==FRAME_DIV-1 (counter wraps to 0 on that edge)
module life_tick_divider
    import life_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 6_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick       = en && (tick_cnt_q == LAST);
        tick_cnt_d = tick_cnt_q;
        if (clear) begin
            tick_cnt_d = '0;
        end else if (en) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/life_frame_scheduler.sv
// life_frame_scheduler: sequences the 8x8 Life engine and hands frames to the display.
//   clk, rst      in   clock, synchronous active-high reset
//   run           in   1 = free-running generations, 0 = paused
//   step          in   one-cycle pulse, requests a single generation while paused
//   frame_in      in   engine output grid
//   calc_strobe   out  registered one-cycle strobe to the engine (time_to_calc_frame)
//   frame_out     out  captured frame; frame_valid flags it as unconsumed
//   disp_ready    in   display accepts frame_out on an edge with frame_valid=1
//   gen_count     out  published generations, wraps
//   busy          out  FSM not in IDLE
//   stalled       out  still-life flag
// Optional feature: define LIFE_STILL_DETECT_EN to enable still-life detection; when
// undefined, stalled is tied to 0.
module life_frame_scheduler
    import life_pkg::*;
#(
    parameter int unsigned FRAME_DIV     = 6_000_000,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned GEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  frame_t           frame_in,
    output logic             calc_strobe,
    output frame_t           frame_out,
    output logic             frame_valid,
    input  logic             disp_ready,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             stalled
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    sched_state_t     state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    frame_t           frame_q, frame_d;
    logic             valid_q, valid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             strobe_q, strobe_d;
    logic             stall_hold;
    logic             tick_en;
    logic             tick;

`ifdef LIFE_STILL_DETECT_EN
    logic stalled_q, stalled_d;
    assign stall_hold = stalled_q;
    assign stalled    = stalled_q;
`else
    assign stall_hold = 1'b0;
    assign stalled    = 1'b0;
`endif

    // Counting only while actually waiting keeps tick_cnt at 0 everywhere else,
    // including while a still life holds the scheduler in WAIT_TICK.
    assign tick_en = (state_q == WAIT_TICK) && run && !stall_hold;

    life_tick_divider #(
        .FRAME_DIV(FRAME_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clear(!tick_en),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        frame_d  = frame_q;
        valid_d  = valid_q;
        gen_d    = gen_q;
`ifdef LIFE_STILL_DETECT_EN
        stalled_d = stalled_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = CALC;
`ifdef LIFE_STILL_DETECT_EN
                    stalled_d = 1'b0;
`endif
                end else if (run) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (!run) begin
                    state_d = IDLE;
`ifdef LIFE_STILL_DETECT_EN
                    stalled_d = 1'b0;
`endif
                end else if (tick) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                state_d  = SETTLE;
                settle_d = '0;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = PUBLISH;
                    frame_d = frame_in;
                    valid_d = 1'b1;
`ifdef LIFE_STILL_DETECT_EN
                    if (frame_in == frame_q) begin
                        stalled_d = 1'b1;
                    end
`endif
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            PUBLISH: begin
                if (valid_q && disp_ready) begin
                    valid_d = 1'b0;
                    gen_d   = gen_q + 1'b1;
                    state_d = run ? WAIT_TICK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobe is registered alongside the state so it is high exactly in the CALC cycle.
        strobe_d = (state_d == CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            frame_q  <= '0;
            valid_q  <= 1'b0;
            gen_q    <= '0;
            strobe_q <= 1'b0;
`ifdef LIFE_STILL_DETECT_EN
            stalled_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            frame_q  <= frame_d;
            valid_q  <= valid_d;
            gen_q    <= gen_d;
            strobe_q <= strobe_d;
`ifdef LIFE_STILL_DETECT_EN
            stalled_q <= stalled_d;
`endif
        end
    end

    assign calc_strobe = strobe_q;
    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign gen_count   = gen_q;
    assign busy        = (state_q != IDLE);

endmodule
